hawk_att_lkup: RTL and testbench
================================

// Module: hawk_att_lkup
// PURPOSE
//  Translates a CPU host page number (hppa) into its ATT entry by fetching the
//  64B ATT block over the AXI read master and extracting one 8B AttEntry.
//  Sits between the control unit (issues att_lkup_reqpkt_t) and hawk_axird_master.
//  Its trnsl_reqpkt_t output feeds the CPU override / page managers.
// PARAMETERS
//  ATT_BASE   HAWK_ATT_START  byte address of ATT entry 0
//  HPPA_BASE  HPPA_BASE_ADDR  byte address mapped to ATT index 0
//  ENTRY_CNT  ATT_ENTRY_CNT   number of valid ATT entries; index >= this is out of range
// PORTS
//  clk_i        in   1    clock
//  rst_i        in   1    synchronous reset, active-high
//  lkup_req_i   in   pkg  att_lkup_reqpkt_t; .lookup is a request strobe, .hppa is a page number
//  lkup_busy_o  in→out 1  high while not IDLE; CU must hold .lookup low while busy
//  rd_req_o     out  pkg  axi_rd_reqpkt_t {addr, arvalid, rready}
//  rd_rdy_i     in   pkg  axi_rd_rdypkt_t {arready}
//  rd_resp_i    in   pkg  axi_rd_resppkt_t {rresp, rdata, rvalid, rlast}
//  trnsl_o      out  pkg  trnsl_reqpkt_t {ppa, sts, allow_access}
//  trnsl_vld_o  out  1    one-cycle pulse qualifying trnsl_o
//  att_entry_o  out  64   raw AttEntry; valid with trnsl_vld_o
//  err_o        out  1    one-cycle pulse: out-of-range index or rresp!=0
//  blk_inval_i  in   1    invalidate the cached block (ignored without HAWK_ATT_BLK_CACHE_EN)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, request registers 0, cache valid=0.
//  Index math: idx = hppa - (HPPA_BASE>>12), 48b unsigned.
//   blk = idx>>3; slot = idx[2:0]; addr = ATT_BASE + (blk<<6), 64b.
//  FSM:
//   IDLE  - on lookup=1, register hppa and go to CHK.
//   CHK   - if idx >= ENTRY_CNT (an underflow wrap also counts): err_o=1, trnsl_vld_o=1,
//           sts=STS_DALLOC, allow_access=0, ppa=0, then IDLE. No AXI traffic.
//         - otherwise go to AR.
//   AR    - arvalid=1 and addr held stable until arready; arvalid drops the next cycle.
//           Then go to RD.
//   RD    - rready=1. Capture rdata on each rvalid. On rvalid&&rlast go to RESP.
//   RESP  - entry = data[slot*64 +: 64]; sts = entry[1:0]; ppa = {4'b0, entry[55:12]}.
//           allow_access = (sts==STS_UNCOMP).
//           If any beat had rresp!=0: err_o=1 and allow_access=0.
//           Pulse trnsl_vld_o, then IDLE.
//  Latency:
//   - miss, zero AXI wait: 4 cycles from lookup to trnsl_vld_o.
//   - out of range: 2 cycles.
//  lookup while busy is ignored, with no queueing.
//  rvalid seen in AR (before arready) is an ordering violation: assertion only.
//  Reset mid-transaction: FSM returns to IDLE. The AXI master is reset in the same domain.
// CONFIGURATION
//  HAWK_ATT_BLK_CACHE_EN defined:
//   - Holds the last fetched 512b block, its blk tag and a valid bit.
//   - In CHK, an in-range request with tag==blk and valid goes directly to RESP.
//     Hit latency is 2 cycles, with no AXI traffic.
//   - The cache is filled in RD on a response with rlast and rresp==0.
//   - blk_inval_i clears valid the next cycle. If it coincides with a fill, inval wins.
//  HAWK_ATT_BLK_CACHE_EN undefined:
//   - Every in-range lookup reads over AXI. blk_inval_i is unused.
// STRUCTURE
//  hacd_pkg gains:
//   - typedef enum att_lkup_state_t {IDLE,CHK,AR,RD,RESP}
//   - function att_blk_addr(hppa)
//   - function att_slot(hppa)
//  Reuses the existing AttEntry, STS_* and packet typedefs.
//  One sub-module, hawk_att_blk_cache: tag, valid and 512b data register with hit/fill/inval.
//  It is instantiated only under the macro.
// TESTING
//  1 hppa=0x80000 (idx 0), ATT word0={zpd 0, way 0x1234000, sts 01}, arready immediate
//    -> addr 0xFFF6100000, ppa=0x1234, allow=1, vld 4 cycles after lookup.
//  2 hppa=0x8000B (blk 1, slot 3), sts=10, arready delayed 5 cycles
//    -> addr 0xFFF6100040 held stable, sts=COMP, allow=0.
//  3 hppa=0x80010 (idx 16 >= ENTRY_CNT), and separately hppa=0x7FFFF
//    -> err_o=1, sts=00, no arvalid, vld after 2 cycles.
//  4 rresp=2'b10 on the read -> err_o=1, allow_access=0, FSM back to IDLE.
//  5 rst_i asserted in RD -> outputs 0 next cycle; a new lookup after reset completes normally.
//  6 [CACHE_EN] lookups 0x80000, then 0x80001 -> second is a hit, 2-cycle latency, no arvalid.
//    Then assert blk_inval_i and repeat 0x80001 -> AXI read issued.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared HACD types and helpers for the ATT lookup path.
// Optional block cache is selected with the HAWK_ATT_BLK_CACHE_EN macro.
package hacd_pkg;

    localparam logic [63:0] HAWK_ATT_START = 64'h0000_00FF_F610_0000;
    localparam logic [63:0] HPPA_BASE_ADDR = 64'h0000_0000_8000_0000;
    localparam int unsigned ATT_ENTRY_CNT  = 16;
    localparam int unsigned ATT_BLK_BITS   = 512;
    localparam int unsigned ATT_BLK_TAG_W  = 45;

    typedef enum logic [1:0] {
        STS_DALLOC = 2'b00,
        STS_UNCOMP = 2'b01,
        STS_COMP   = 2'b10,
        STS_INCOMP = 2'b11
    } att_sts_t;

    typedef struct packed {
        logic [7:0]  zpd_cnt;
        logic [43:0] way;
        logic [9:0]  rsvd;
        att_sts_t    sts;
    } AttEntry;

    typedef struct packed {
        logic        lookup;
        logic [47:0] hppa;
    } att_lkup_reqpkt_t;

    typedef struct packed {
        logic [63:0] addr;
        logic        arvalid;
        logic        rready;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic arready;
    } axi_rd_rdypkt_t;

    typedef struct packed {
        logic [1:0]              rresp;
        logic [ATT_BLK_BITS-1:0] rdata;
        logic                    rvalid;
        logic                    rlast;
    } axi_rd_resppkt_t;

    typedef struct packed {
        logic [47:0] ppa;
        att_sts_t    sts;
        logic        allow_access;
    } trnsl_reqpkt_t;

    typedef enum logic [2:0] {IDLE, CHK, AR, RD, RESP} att_lkup_state_t;

    // ATT index of a host page; a page below the base wraps to a huge index.
    function automatic logic [47:0] att_idx(input logic [47:0] hppa,
                                            input logic [63:0] hppa_base = HPPA_BASE_ADDR);
        return hppa - hppa_base[59:12];
    endfunction

    // 64B block number holding the entry, used as the cache tag.
    function automatic logic [ATT_BLK_TAG_W-1:0] att_blk(input logic [47:0] hppa,
                                                         input logic [63:0] hppa_base = HPPA_BASE_ADDR);
        logic [47:0] idx;
        idx = att_idx(hppa, hppa_base);
        return idx[47:3];
    endfunction

    // Byte address of the 64B ATT block containing the entry.
    function automatic logic [63:0] att_blk_addr(input logic [47:0] hppa,
                                                 input logic [63:0] att_base  = HAWK_ATT_START,
                                                 input logic [63:0] hppa_base = HPPA_BASE_ADDR);
        return att_base + {13'b0, att_blk(hppa, hppa_base), 6'b0};
    endfunction

    // Entry position within its 64B block.
    function automatic logic [2:0] att_slot(input logic [47:0] hppa,
                                            input logic [63:0] hppa_base = HPPA_BASE_ADDR);
        logic [47:0] idx;
        idx = att_idx(hppa, hppa_base);
        return idx[2:0];
    endfunction

    // Translation result for an entry; a bus error always denies access.
    function automatic trnsl_reqpkt_t att_resolve(input AttEntry entry, input logic rd_err);
        trnsl_reqpkt_t t;
        t.ppa          = {4'b0, entry.way};
        t.sts          = entry.sts;
        t.allow_access = (entry.sts == STS_UNCOMP) && !rd_err;
        return t;
    endfunction

endpackage

// File: rtl/hawk_att_blk_cache.sv
// Single-block ATT cache: last fetched 512b block, its block tag and a valid bit.
// Only built when HAWK_ATT_BLK_CACHE_EN is defined.
module hawk_att_blk_cache
    import hacd_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ATT_BLK_TAG_W-1:0] lkup_blk_i,
    output logic                     hit_o,
    output logic [ATT_BLK_BITS-1:0]  data_o,
    input  logic                     fill_i,
    input  logic [ATT_BLK_TAG_W-1:0] fill_blk_i,
    input  logic [ATT_BLK_BITS-1:0]  fill_data_i,
    input  logic                     inval_i
);

    logic                     valid_q, valid_d;
    logic [ATT_BLK_TAG_W-1:0] tag_q, tag_d;
    logic [ATT_BLK_BITS-1:0]  data_q, data_d;

    // Next-state for fill and invalidate; invalidate has priority over a fill.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_blk_i;
            data_d  = fill_data_i;
        end
        if (inval_i) begin
            valid_d = 1'b0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    // Block data storage.
    always_ff @(posedge clk_i) begin
        // NOTE: the data array is not reset; valid_q alone guards its use.
        data_q <= data_d;
    end

    assign hit_o  = valid_q && (tag_q == lkup_blk_i);
    assign data_o = data_q;

endmodule

// File: rtl/hawk_att_lkup.sv
// ATT lookup: turns a host page number into its 8B ATT entry by reading the
// 64B ATT block over the AXI read master.
// Optional single-block cache: define HAWK_ATT_BLK_CACHE_EN.
module hawk_att_lkup
    import hacd_pkg::*;
#(
    parameter logic [63:0] ATT_BASE  = HAWK_ATT_START,
    parameter logic [63:0] HPPA_BASE = HPPA_BASE_ADDR,
    parameter int unsigned ENTRY_CNT = ATT_ENTRY_CNT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  att_lkup_reqpkt_t lkup_req_i,
    output logic             lkup_busy_o,
    output axi_rd_reqpkt_t   rd_req_o,
    input  axi_rd_rdypkt_t   rd_rdy_i,
    input  axi_rd_resppkt_t  rd_resp_i,
    output trnsl_reqpkt_t    trnsl_o,
    output logic             trnsl_vld_o,
    output logic [63:0]      att_entry_o,
    output logic             err_o,
    input  logic             blk_inval_i
);

    att_lkup_state_t state_q, state_d;
    logic [47:0]     hppa_q, hppa_d;
    logic [63:0]     addr_q, addr_d;
    logic            rresp_err_q, rresp_err_d;
    trnsl_reqpkt_t   trnsl_q, trnsl_d;
    logic [63:0]     att_entry_q, att_entry_d;
    logic            trnsl_vld_q, trnsl_vld_d;
    logic            err_q, err_d;

    logic [47:0]             idx;
    logic                    rd_err;
    logic [ATT_BLK_BITS-1:0] src_data;
    AttEntry                 sel_entry;
    logic                    fill_en;
    logic                    cache_hit;
    logic [ATT_BLK_BITS-1:0] cache_data;

`ifdef HAWK_ATT_BLK_CACHE_EN
    hawk_att_blk_cache u_blk_cache (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lkup_blk_i  (att_blk(hppa_q, HPPA_BASE)),
        .hit_o       (cache_hit),
        .data_o      (cache_data),
        .fill_i      (fill_en),
        .fill_blk_i  (att_blk(hppa_q, HPPA_BASE)),
        .fill_data_i (rd_resp_i.rdata),
        .inval_i     (blk_inval_i)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
    wire unused_cache_ifc = blk_inval_i | fill_en;
`endif

    // Lookup FSM: next state plus the registered translation result.
    always_comb begin
        state_d     = state_q;
        hppa_d      = hppa_q;
        addr_d      = addr_q;
        rresp_err_d = rresp_err_q;
        trnsl_d     = trnsl_q;
        att_entry_d = att_entry_q;
        trnsl_vld_d = 1'b0;
        err_d       = 1'b0;
        fill_en     = 1'b0;

        idx       = att_idx(hppa_q, HPPA_BASE);
        rd_err    = rresp_err_q || (rd_resp_i.rresp != 2'b00);
        // A hit resolves from the cache in CHK; a miss resolves from the last beat in RD.
        src_data  = (state_q == CHK) ? cache_data : rd_resp_i.rdata;
        sel_entry = AttEntry'(src_data[{att_slot(hppa_q, HPPA_BASE), 6'd0} +: 64]);

        unique case (state_q)
            IDLE: begin
                if (lkup_req_i.lookup) begin
                    hppa_d      = lkup_req_i.hppa;
                    rresp_err_d = 1'b0;
                    state_d     = CHK;
                end
            end
            CHK: begin
                if (idx >= 48'(ENTRY_CNT)) begin
                    trnsl_d.ppa          = '0;
                    trnsl_d.sts          = STS_DALLOC;
                    trnsl_d.allow_access = 1'b0;
                    att_entry_d          = '0;
                    trnsl_vld_d          = 1'b1;
                    err_d                = 1'b1;
                    state_d              = IDLE;
                end else if (cache_hit) begin
                    trnsl_d     = att_resolve(sel_entry, 1'b0);
                    att_entry_d = sel_entry;
                    trnsl_vld_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    addr_d  = att_blk_addr(hppa_q, ATT_BASE, HPPA_BASE);
                    state_d = AR;
                end
            end
            AR: begin
                if (rd_rdy_i.arready) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (rd_resp_i.rvalid) begin
                    rresp_err_d = rd_err;
                    if (rd_resp_i.rlast) begin
                        trnsl_d     = att_resolve(sel_entry, rd_err);
                        att_entry_d = sel_entry;
                        trnsl_vld_d = 1'b1;
                        err_d       = rd_err;
                        fill_en     = !rd_err;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hppa_q      <= '0;
            addr_q      <= '0;
            rresp_err_q <= 1'b0;
            trnsl_q     <= '0;
            att_entry_q <= '0;
            trnsl_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hppa_q      <= hppa_d;
            addr_q      <= addr_d;
            rresp_err_q <= rresp_err_d;
            trnsl_q     <= trnsl_d;
            att_entry_q <= att_entry_d;
            trnsl_vld_q <= trnsl_vld_d;
            err_q       <= err_d;
        end
    end

    // AXI request channel driven straight from state and the held address.
    always_comb begin
        rd_req_o.addr    = addr_q;
        rd_req_o.arvalid = (state_q == AR);
        rd_req_o.rready  = (state_q == RD);
    end

    assign lkup_busy_o = (state_q != IDLE);
    assign trnsl_o     = trnsl_q;
    assign trnsl_vld_o = trnsl_vld_q;
    assign att_entry_o = att_entry_q;
    assign err_o       = err_q;

    // Read data must never arrive before the address handshake.
    ap_no_early_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        !((state_q == AR) && rd_resp_i.rvalid));

endmodule

// File: tb/tb_hawk_att_lkup.sv
// Directed bench for hawk_att_lkup; cache steps run when HAWK_ATT_BLK_CACHE_EN is defined.
module tb_hawk_att_lkup;
    import hacd_pkg::*;

    localparam logic [63:0] E0  = 64'h0000_0000_0123_4001;
    localparam logic [63:0] E1  = 64'h0000_0000_0555_5001;
    localparam logic [63:0] E11 = 64'h0500_0000_ABCD_E002;
    localparam logic [63:0] EXP_BASE = 64'h0000_00FF_F610_0000;

    logic             clk_i = 1'b0;
    logic             rst_i;
    att_lkup_reqpkt_t lkup_req;
    logic             lkup_busy;
    axi_rd_reqpkt_t   rd_req;
    axi_rd_rdypkt_t   rd_rdy;
    axi_rd_resppkt_t  rd_resp;
    trnsl_reqpkt_t    trnsl;
    logic             trnsl_vld;
    logic [63:0]      att_entry;
    logic             err;
    logic             blk_inval;

    logic [63:0] att_mem [16];

    int n_assert = 0;
    int n_fail   = 0;

    int            obs_vld_cyc;
    int            obs_vld_cnt;
    int            obs_err_cnt;
    int            obs_ar_cyc;
    int            obs_timeout;
    logic          obs_addr_stable;
    logic [63:0]   obs_addr;
    trnsl_reqpkt_t obs_trnsl;
    logic [63:0]   obs_entry;

    hawk_att_lkup dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lkup_req_i  (lkup_req),
        .lkup_busy_o (lkup_busy),
        .rd_req_o    (rd_req),
        .rd_rdy_i    (rd_rdy),
        .rd_resp_i   (rd_resp),
        .trnsl_o     (trnsl),
        .trnsl_vld_o (trnsl_vld),
        .att_entry_o (att_entry),
        .err_o       (err),
        .blk_inval_i (blk_inval)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] blk_data(input logic [63:0] addr);
        logic [511:0] d;
        logic [63:0]  b;
        d = '0;
        b = (addr - EXP_BASE) >> 6;
        if (b < 64'd2) begin
            for (int s = 0; s < 8; s++) d[s*64 +: 64] = att_mem[int'(b)*8 + s];
        end
        return d;
    endfunction

    // Issue one lookup and act as the AXI slave until the result drains.
    task automatic run_lookup(input logic [47:0] hppa, input int ar_wait, input logic [1:0] rresp);
        int ar_cnt;
        bit r_pend;
        bit done;
        obs_vld_cyc = -1; obs_vld_cnt = 0; obs_err_cnt = 0; obs_ar_cyc = 0;
        obs_timeout = 0; obs_addr_stable = 1'b1; obs_addr = '0;
        obs_trnsl = '0; obs_entry = '0;
        ar_cnt = 0; r_pend = 1'b0; done = 1'b0;
        @(negedge clk_i);
        lkup_req.lookup = 1'b1;
        lkup_req.hppa   = hppa;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk_i);
            lkup_req.lookup = 1'b0;
            lkup_req.hppa   = '0;
            rd_rdy.arready  = 1'b0;
            rd_resp         = '0;
            if (rd_req.arvalid) begin
                if (obs_ar_cyc == 0) obs_addr = rd_req.addr;
                else if (rd_req.addr !== obs_addr) obs_addr_stable = 1'b0;
                obs_ar_cyc++;
                if (ar_cnt == ar_wait) begin
                    rd_rdy.arready = 1'b1;
                    r_pend = 1'b1;
                end
                ar_cnt++;
            end else if (rd_req.rready && r_pend) begin
                rd_resp.rvalid = 1'b1;
                rd_resp.rlast  = 1'b1;
                rd_resp.rdata  = blk_data(obs_addr);
                rd_resp.rresp  = rresp;
                r_pend = 1'b0;
            end
            if (err) obs_err_cnt++;
            if (trnsl_vld) begin
                obs_vld_cnt++;
                if (obs_vld_cyc < 0) begin
                    obs_vld_cyc = cyc;
                    obs_trnsl   = trnsl;
                    obs_entry   = att_entry;
                end
            end
            if (obs_vld_cyc >= 0 && !lkup_busy) done = 1'b1;
        end
        @(negedge clk_i);
        rd_resp = '0;
        if (trnsl_vld) obs_vld_cnt++;
        if (err) obs_err_cnt++;
        if (!done) obs_timeout = 1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) att_mem[i] = {8'h00, 44'(48'h300 + 48'(i)), 10'h0, 2'b11};
        att_mem[0]  = E0;
        att_mem[1]  = E1;
        att_mem[11] = E11;

        rst_i = 1'b1;
        lkup_req = '0;
        rd_rdy = '0;
        rd_resp = '0;
        blk_inval = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", 64'(lkup_busy), 64'd0);
        check("rst_vld", 64'(trnsl_vld), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_arvalid", 64'(rd_req.arvalid), 64'd0);
        check("rst_addr", rd_req.addr, 64'd0);
        check("rst_trnsl", 64'(trnsl), 64'd0);
        rst_i = 1'b0;

        // 1: idx 0, arready immediate
        run_lookup(48'h80000, 0, 2'b00);
        check("t1_timeout", 64'(obs_timeout), 64'd0);
        check("t1_addr", obs_addr, 64'h0000_00FF_F610_0000);
        check("t1_lat", 64'(obs_vld_cyc), 64'd4);
        check("t1_ppa", 64'(obs_trnsl.ppa), 64'h1234);
        check("t1_sts", 64'(obs_trnsl.sts), 64'd1);
        check("t1_allow", 64'(obs_trnsl.allow_access), 64'd1);
        check("t1_entry", obs_entry, E0);
        check("t1_err", 64'(obs_err_cnt), 64'd0);
        check("t1_vld_cnt", 64'(obs_vld_cnt), 64'd1);

        // 2: blk 1 slot 3, arready after 5 waits
        run_lookup(48'h8000B, 5, 2'b00);
        check("t2_addr", obs_addr, 64'h0000_00FF_F610_0040);
        check("t2_addr_stable", 64'(obs_addr_stable), 64'd1);
        check("t2_ar_cycles", 64'(obs_ar_cyc), 64'd6);
        check("t2_lat", 64'(obs_vld_cyc), 64'd9);
        check("t2_sts", 64'(obs_trnsl.sts), 64'd2);
        check("t2_allow", 64'(obs_trnsl.allow_access), 64'd0);
        check("t2_ppa", 64'(obs_trnsl.ppa), 64'hABCDE);
        check("t2_entry", obs_entry, E11);

        // 3: out of range above and below
        run_lookup(48'h80010, 0, 2'b00);
        check("t3a_err", 64'(obs_err_cnt), 64'd1);
        check("t3a_sts", 64'(obs_trnsl.sts), 64'd0);
        check("t3a_allow", 64'(obs_trnsl.allow_access), 64'd0);
        check("t3a_ar", 64'(obs_ar_cyc), 64'd0);
        check("t3a_lat", 64'(obs_vld_cyc), 64'd2);
        check("t3a_vld_cnt", 64'(obs_vld_cnt), 64'd1);
        run_lookup(48'h7FFFF, 0, 2'b00);
        check("t3b_err", 64'(obs_err_cnt), 64'd1);
        check("t3b_ar", 64'(obs_ar_cyc), 64'd0);
        check("t3b_lat", 64'(obs_vld_cyc), 64'd2);
        check("t3b_ppa", 64'(obs_trnsl.ppa), 64'd0);

        // 4: SLVERR on the read of an otherwise allowed entry
        run_lookup(48'h80001, 0, 2'b10);
        check("t4_err", 64'(obs_err_cnt), 64'd1);
        check("t4_allow", 64'(obs_trnsl.allow_access), 64'd0);
        check("t4_lat", 64'(obs_vld_cyc), 64'd4);
        check("t4_idle", 64'(lkup_busy), 64'd0);

        // 5: reset while in RD, then a clean lookup
        @(negedge clk_i);
        lkup_req.lookup = 1'b1;
        lkup_req.hppa   = 48'h80001;
        @(negedge clk_i);
        lkup_req = '0;
        @(negedge clk_i);
        check("t5_arvalid", 64'(rd_req.arvalid), 64'd1);
        rd_rdy.arready = 1'b1;
        @(negedge clk_i);
        rd_rdy.arready = 1'b0;
        check("t5_in_rd", 64'(rd_req.rready), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("t5_rst_busy", 64'(lkup_busy), 64'd0);
        check("t5_rst_rready", 64'(rd_req.rready), 64'd0);
        check("t5_rst_vld", 64'(trnsl_vld), 64'd0);
        rst_i = 1'b0;
        run_lookup(48'h80001, 0, 2'b00);
        check("t5_ppa", 64'(obs_trnsl.ppa), 64'h5555);
        check("t5_allow", 64'(obs_trnsl.allow_access), 64'd1);
        check("t5_lat", 64'(obs_vld_cyc), 64'd4);
        check("t5_err", 64'(obs_err_cnt), 64'd0);

`ifdef HAWK_ATT_BLK_CACHE_EN
        // 6: miss fills, neighbour hits, invalidate forces a re-read
        @(negedge clk_i);
        blk_inval = 1'b1;
        @(negedge clk_i);
        blk_inval = 1'b0;
        run_lookup(48'h80000, 0, 2'b00);
        check("t6_miss_ar", 64'(obs_ar_cyc), 64'd1);
        run_lookup(48'h80001, 0, 2'b00);
        check("t6_hit_ar", 64'(obs_ar_cyc), 64'd0);
        check("t6_hit_lat", 64'(obs_vld_cyc), 64'd2);
        check("t6_hit_ppa", 64'(obs_trnsl.ppa), 64'h5555);
        check("t6_hit_allow", 64'(obs_trnsl.allow_access), 64'd1);
        @(negedge clk_i);
        blk_inval = 1'b1;
        @(negedge clk_i);
        blk_inval = 1'b0;
        run_lookup(48'h80001, 0, 2'b00);
        check("t6_inval_ar", 64'(obs_ar_cyc), 64'd1);
        check("t6_inval_lat", 64'(obs_vld_cyc), 64'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
